// File: rtl/pong_match_ctrl.sv
// Match sequencer for the LED ping-pong rally: serve control, ball-step tick,
// speed-up on returns, scoring and match end detection.
module pong_match_ctrl #(
    parameter int unsigned      CNT_W        = 25,
    parameter int unsigned      WIN_SCORE    = 9,
    parameter logic [CNT_W-1:0] TICK_INIT    = 25'd12_500_000,
    parameter logic [CNT_W-1:0] TICK_MIN     = 25'd2_500_000,
    parameter logic [CNT_W-1:0] TICK_STEP    = 25'd1_000_000,
    parameter logic [CNT_W-1:0] PAUSE_CYCLES = 25'd25_000_000
) (
    input  logic       clk_game,
    input  logic       rst,
    input  logic       LeftSw,
    input  logic       RightSw,
    input  logic       hit,
    input  logic       point_left,
    input  logic       point_right,
    output logic       tick,
    output logic       rally_start,
    output logic       rally_active,
    output logic       serve_left,
    output logic       serve_req,
    output logic [3:0] Score_Left,
    output logic [3:0] Score_Right,
    output logic [3:0] speed_level,
    output logic       match_over,
    output logic       winner_left
);

    typedef enum logic [2:0] {
        IDLE,
        SERVE_WAIT,
        RALLY,
        POINT_PAUSE,
        MATCH_OVER
    } state_t;

    localparam logic [3:0]       WIN        = 4'(WIN_SCORE);
    localparam logic [CNT_W-1:0] ONE        = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W:0]   FLOOR      = {1'b0, TICK_MIN} + {1'b0, TICK_STEP};
    localparam logic [CNT_W-1:0] PAUSE_LAST = PAUSE_CYCLES - ONE;

    state_t state, state_d;

    logic l_s1, l_s2, l_prev, press_l;
    logic r_s1, r_s2, r_prev, press_r;

    // period is the pending value; cur_period is what the divider uses
    // until the next wrap, so a hit never shortens an interval in flight
    logic [CNT_W-1:0] period, period_d, period_hit;
    logic [CNT_W-1:0] cur_period, cur_d;
    logic [CNT_W-1:0] div, div_d;
    logic [CNT_W-1:0] pause, pause_d;
    logic [3:0]       score_l_d, score_r_d, speed_d;
    logic             serve_l_d, win_l_d, tick_d;

    always_ff @(posedge clk_game or negedge rst) begin
        if (!rst) begin
            l_s1    <= 1'b0;
            l_s2    <= 1'b0;
            l_prev  <= 1'b0;
            press_l <= 1'b0;
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_prev  <= 1'b0;
            press_r <= 1'b0;
        end else begin
            l_s1    <= LeftSw;
            l_s2    <= l_s1;
            l_prev  <= l_s2;
            press_l <= l_s2 & ~l_prev;
            r_s1    <= RightSw;
            r_s2    <= r_s1;
            r_prev  <= r_s2;
            press_r <= r_s2 & ~r_prev;
        end
    end

    always_comb begin
        if ({1'b0, period} >= FLOOR) begin
            period_hit = period - TICK_STEP;
        end else begin
            period_hit = TICK_MIN;
        end
    end

    always_comb begin
        state_d   = state;
        period_d  = period;
        cur_d     = cur_period;
        div_d     = div;
        pause_d   = pause;
        score_l_d = Score_Left;
        score_r_d = Score_Right;
        speed_d   = speed_level;
        serve_l_d = serve_left;
        win_l_d   = winner_left;
        tick_d    = 1'b0;
        unique case (state)
            IDLE: begin
                if (press_l | press_r) begin
                    state_d = SERVE_WAIT;
                end
            end
            SERVE_WAIT: begin
                if (serve_left ? press_l : press_r) begin
                    state_d  = RALLY;
                    period_d = TICK_INIT;
                    cur_d    = TICK_INIT;
                    div_d    = '0;
                    speed_d  = 4'd0;
                end
            end
            RALLY: begin
                if (div == cur_period - ONE) begin
                    div_d  = '0;
                    tick_d = 1'b1;
                end else begin
                    div_d = div + ONE;
                end
                if (point_left & point_right) begin
                    state_d = POINT_PAUSE;
                end else if (point_left) begin
                    score_l_d = Score_Left + 4'd1;
                    serve_l_d = 1'b0;
                    if (score_l_d == WIN) begin
                        state_d = MATCH_OVER;
                        win_l_d = 1'b1;
                    end else begin
                        state_d = POINT_PAUSE;
                    end
                end else if (point_right) begin
                    score_r_d = Score_Right + 4'd1;
                    serve_l_d = 1'b1;
                    if (score_r_d == WIN) begin
                        state_d = MATCH_OVER;
                        win_l_d = 1'b0;
                    end else begin
                        state_d = POINT_PAUSE;
                    end
                end else if (hit) begin
                    period_d = period_hit;
                    if (period_hit < period && speed_level != 4'hf) begin
                        speed_d = speed_level + 4'd1;
                    end
                end
                if (tick_d) begin
                    cur_d = period_d;
                end
                if (state_d != RALLY) begin
                    tick_d  = 1'b0;
                    pause_d = '0;
                end
            end
            POINT_PAUSE: begin
                if (pause == PAUSE_LAST) begin
                    state_d = SERVE_WAIT;
                end else begin
                    pause_d = pause + ONE;
                end
            end
            MATCH_OVER: begin
                if ((press_l & r_s2) | (press_r & l_s2)) begin
                    state_d   = IDLE;
                    score_l_d = 4'd0;
                    score_r_d = 4'd0;
                    serve_l_d = 1'b1;
                    win_l_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_game or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            period       <= TICK_INIT;
            cur_period   <= TICK_INIT;
            div          <= '0;
            pause        <= '0;
            Score_Left   <= 4'd0;
            Score_Right  <= 4'd0;
            speed_level  <= 4'd0;
            serve_left   <= 1'b1;
            winner_left  <= 1'b0;
            tick         <= 1'b0;
            rally_start  <= 1'b0;
            rally_active <= 1'b0;
            serve_req    <= 1'b0;
            match_over   <= 1'b0;
        end else begin
            state        <= state_d;
            period       <= period_d;
            cur_period   <= cur_d;
            div          <= div_d;
            pause        <= pause_d;
            Score_Left   <= score_l_d;
            Score_Right  <= score_r_d;
            speed_level  <= speed_d;
            serve_left   <= serve_l_d;
            winner_left  <= win_l_d;
            tick         <= tick_d;
            rally_start  <= (state == SERVE_WAIT) && (state_d == RALLY);
            rally_active <= (state_d == RALLY);
            serve_req    <= (state_d == SERVE_WAIT);
            match_over   <= (state_d == MATCH_OVER);
        end
    end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl with small timing parameters.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_pong_match_ctrl;

    logic       clk_game = 1'b0;
    logic       rst = 1'b0;
    logic       LeftSw = 1'b0;
    logic       RightSw = 1'b0;
    logic       hit = 1'b0;
    logic       point_left = 1'b0;
    logic       point_right = 1'b0;
    logic       tick, rally_start, rally_active, serve_left, serve_req;
    logic [3:0] Score_Left, Score_Right, speed_level;
    logic       match_over, winner_left;

    int checks = 0;
    int errors = 0;

    localparam logic [18:0] RST_V = {5'b00010, 14'b0};
    logic [18:0] outv;
    assign outv = {tick, rally_start, rally_active, serve_left, serve_req,
                   Score_Left, Score_Right, speed_level, match_over, winner_left};

    pong_match_ctrl #(
        .CNT_W       (25),
        .WIN_SCORE   (3),
        .TICK_INIT   (25'd8),
        .TICK_MIN    (25'd4),
        .TICK_STEP   (25'd3),
        .PAUSE_CYCLES(25'd5)
    ) dut (
        .clk_game    (clk_game),
        .rst         (rst),
        .LeftSw      (LeftSw),
        .RightSw     (RightSw),
        .hit         (hit),
        .point_left  (point_left),
        .point_right (point_right),
        .tick        (tick),
        .rally_start (rally_start),
        .rally_active(rally_active),
        .serve_left  (serve_left),
        .serve_req   (serve_req),
        .Score_Left  (Score_Left),
        .Score_Right (Score_Right),
        .speed_level (speed_level),
        .match_over  (match_over),
        .winner_left (winner_left)
    );

    always #5 clk_game = ~clk_game;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit hit, required a finished run");
        $fatal(1);
    end

    // Press becomes visible in the FSM outputs 4 edges after the switch rises.
    task automatic pulse_sw(input logic l, input logic r);
        repeat (3) @(negedge clk_game);
        LeftSw  = l;
        RightSw = r;
        repeat (4) @(negedge clk_game);
        LeftSw  = 1'b0;
        RightSw = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk_game);
        checks++;
        if (outv !== RST_V) begin
            errors++;
            $display("FAIL reset_vals: got %b expected %b", outv, RST_V);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk_game);
        checks++;
        if (outv !== RST_V) begin
            errors++;
            $display("FAIL idle_vals: got %b expected %b", outv, RST_V);
        end
    endtask

    task automatic test_serve();
        logic exp_t;
        pulse_sw(1'b1, 1'b0);
        checks++;
        if ({serve_req, rally_active} !== 2'b10) begin
            errors++;
            $display("FAIL idle_to_serve: got req/act %b expected 10",
                     {serve_req, rally_active});
        end
        pulse_sw(1'b0, 1'b1);
        checks++;
        if ({serve_req, rally_start, rally_active} !== 3'b100) begin
            errors++;
            $display("FAIL wrong_server: got req/start/act %b expected 100",
                     {serve_req, rally_start, rally_active});
        end
        pulse_sw(1'b1, 1'b0);
        checks++;
        if ({serve_req, rally_start, rally_active, speed_level} !== 7'b0110000) begin
            errors++;
            $display("FAIL rally_start: got req/start/act/spd %b expected 0110000",
                     {serve_req, rally_start, rally_active, speed_level});
        end
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk_game);
            exp_t = (k == 8) || (k == 16);
            checks++;
            if ({tick, rally_start, rally_active} !== {exp_t, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL tick_init k=%0d: got tick/start/act %b expected %b",
                         k, {tick, rally_start, rally_active}, {exp_t, 2'b01});
            end
        end
    endtask

    task automatic test_speed();
        logic       exp_t;
        logic [3:0] exp_s;
        for (int k = 0; k <= 21; k++) begin
            exp_t = (k == 0) || (k == 8) || (k == 13) || (k == 17) || (k == 21);
            exp_s = (k == 0) ? 4'd0 : ((k < 9) ? 4'd1 : 4'd2);
            checks++;
            if ({tick, speed_level} !== {exp_t, exp_s}) begin
                errors++;
                $display("FAIL speed k=%0d: got tick=%b spd=%0d expected tick=%b spd=%0d",
                         k, tick, speed_level, exp_t, exp_s);
            end
            hit = (k == 0) || (k == 8) || (k == 13);
            @(negedge clk_game);
        end
        hit = 1'b0;
    endtask

    task automatic test_point_left();
        point_left = 1'b1;
        @(negedge clk_game);
        point_left = 1'b0;
        checks++;
        if ({Score_Left, Score_Right, serve_left, rally_active, tick}
            !== {4'd1, 4'd0, 3'b000}) begin
            errors++;
            $display("FAIL point_left: got L=%0d R=%0d srv=%b act=%b tick=%b expected 1 0 0 0 0",
                     Score_Left, Score_Right, serve_left, rally_active, tick);
        end
        for (int i = 1; i <= 4; i++) begin
            point_right = (i == 2);
            hit         = (i == 3);
            @(negedge clk_game);
            checks++;
            if ({tick, serve_req, rally_active, Score_Right} !== 7'b0000000) begin
                errors++;
                $display("FAIL pause i=%0d: got tick/req/act=%b R=%0d expected 000 R=0",
                         i, {tick, serve_req, rally_active}, Score_Right);
            end
        end
        point_right = 1'b0;
        hit         = 1'b0;
        @(negedge clk_game);
        checks++;
        if (serve_req !== 1'b1) begin
            errors++;
            $display("FAIL pause_end: got serve_req=%b expected 1", serve_req);
        end
        pulse_sw(1'b1, 1'b0);
        checks++;
        if ({serve_req, rally_active} !== 2'b10) begin
            errors++;
            $display("FAIL left_ignored: got req/act %b expected 10",
                     {serve_req, rally_active});
        end
        pulse_sw(1'b0, 1'b1);
        checks++;
        if ({rally_start, rally_active, speed_level} !== 6'b110000) begin
            errors++;
            $display("FAIL right_serve: got start/act/spd %b expected 110000",
                     {rally_start, rally_active, speed_level});
        end
    endtask

    task automatic test_both_points();
        point_left  = 1'b1;
        point_right = 1'b1;
        @(negedge clk_game);
        point_left  = 1'b0;
        point_right = 1'b0;
        checks++;
        if ({Score_Left, Score_Right, serve_left, rally_active, serve_req}
            !== {4'd1, 4'd0, 3'b000}) begin
            errors++;
            $display("FAIL replay: got L=%0d R=%0d srv=%b act=%b req=%b expected 1 0 0 0 0",
                     Score_Left, Score_Right, serve_left, rally_active, serve_req);
        end
        repeat (5) @(negedge clk_game);
        checks++;
        if ({serve_req, serve_left} !== 2'b10) begin
            errors++;
            $display("FAIL replay_serve: got req/srv %b expected 10",
                     {serve_req, serve_left});
        end
        pulse_sw(1'b0, 1'b1);
        checks++;
        if (rally_start !== 1'b1) begin
            errors++;
            $display("FAIL replay_start: got rally_start=%b expected 1", rally_start);
        end
    endtask

    task automatic test_match_over();
        for (int i = 0; i < 3; i++) begin
            point_right = 1'b1;
            @(negedge clk_game);
            point_right = 1'b0;
            checks++;
            if (Score_Right !== 4'(i + 1)) begin
                errors++;
                $display("FAIL right_score i=%0d: got %0d expected %0d",
                         i, Score_Right, i + 1);
            end
            if (i < 2) begin
                repeat (5) @(negedge clk_game);
                pulse_sw(1'b1, 1'b0);
                checks++;
                if (rally_start !== 1'b1) begin
                    errors++;
                    $display("FAIL left_serve i=%0d: got rally_start=%b expected 1",
                             i, rally_start);
                end
            end
        end
        checks++;
        if ({match_over, winner_left, rally_active, Score_Left} !== {3'b100, 4'd1}) begin
            errors++;
            $display("FAIL match_end: got over/win/act=%b L=%0d expected 100 L=1",
                     {match_over, winner_left, rally_active}, Score_Left);
        end
        point_left  = 1'b1;
        @(negedge clk_game);
        point_left  = 1'b0;
        point_right = 1'b1;
        @(negedge clk_game);
        point_right = 1'b0;
        @(negedge clk_game);
        checks++;
        if ({Score_Left, Score_Right, match_over} !== {4'd1, 4'd3, 1'b1}) begin
            errors++;
            $display("FAIL frozen: got L=%0d R=%0d over=%b expected 1 3 1",
                     Score_Left, Score_Right, match_over);
        end
        pulse_sw(1'b1, 1'b0);
        checks++;
        if (match_over !== 1'b1) begin
            errors++;
            $display("FAIL single_sw: got match_over=%b expected 1", match_over);
        end
        pulse_sw(1'b1, 1'b1);
        checks++;
        if (outv !== RST_V) begin
            errors++;
            $display("FAIL match_clear: got %b expected %b", outv, RST_V);
        end
    endtask

    task automatic test_reset_mid_rally();
        pulse_sw(1'b1, 1'b0);
        pulse_sw(1'b1, 1'b0);
        checks++;
        if (rally_start !== 1'b1) begin
            errors++;
            $display("FAIL rerally: got rally_start=%b expected 1", rally_start);
        end
        hit = 1'b1;
        @(negedge clk_game);
        hit = 1'b0;
        repeat (2) @(negedge clk_game);
        checks++;
        if ({rally_active, speed_level} !== 5'b10001) begin
            errors++;
            $display("FAIL pre_reset: got act/spd %b expected 10001",
                     {rally_active, speed_level});
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (outv !== RST_V) begin
            errors++;
            $display("FAIL async_reset: got %b expected %b", outv, RST_V);
        end
        repeat (2) @(negedge clk_game);
        rst = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_game);
            checks++;
            if ({tick, rally_active, serve_req} !== 3'b000) begin
                errors++;
                $display("FAIL post_reset k=%0d: got tick/act/req %b expected 000",
                         k, {tick, rally_active, serve_req});
            end
        end
        pulse_sw(1'b1, 1'b0);
        checks++;
        if ({serve_req, rally_active} !== 2'b10) begin
            errors++;
            $display("FAIL post_reset_serve: got req/act %b expected 10",
                     {serve_req, rally_active});
        end
    endtask

    initial begin
        test_reset();
        test_serve();
        test_speed();
        test_point_left();
        test_both_points();
        test_match_over();
        test_reset_mid_rally();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
